// File: rtl/irq_sched.sv
`default_nettype none
// ============================================================================
//  Module   : irq_sched
//  Purpose  : Synchronizes board interrupt buttons, arbitrates nested levels
//             and redirects the pipeline through a flush-then-jump handshake.
//  Revision : 1.0
// ============================================================================
module irq_sched #(
    parameter logic [31:0] VEC0      = 32'h0000_0400,
    parameter logic [31:0] VEC1      = 32'h0000_0500,
    parameter logic [31:0] VEC2      = 32'h0000_0600,
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic        clk,
    input  logic        in_RST,
    input  logic [2:0]  irq_btn,
    input  logic        ie,
    input  logic [2:0]  im,
    input  logic        pipe_ack,
    input  logic        eret,
    output logic        int_req,
    output logic        fd_clr,
    output logic        de_clr,
    output logic        ee_clr,
    output logic        pc_force,
    output logic [31:0] faddr,
    output logic        save_epc,
    output logic [2:0]  pending,
    output logic [2:0]  in_service,
    output logic [2:0]  leds
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_req   = 2'd1;
    localparam logic [1:0] c_flush = 2'd2;
    localparam logic [1:0] c_jump  = 2'd3;

    localparam logic [2:0] c_flush_last = 3'(FLUSH_CYC - 1);

    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] r_sync3;
    logic [2:0] w_edge;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [1:0] r_sel;
    logic [1:0] w_sel_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;

    logic [2:0] r_pending;
    logic [2:0] w_pending_nxt;
    logic [2:0] r_in_service;
    logic [2:0] w_isv_pop;
    logic [2:0] w_isv_nxt;

    logic [2:0] w_above;
    logic [2:0] w_elig;
    logic       w_any;
    logic [1:0] w_win;
    logic [2:0] w_sel_oh;
    logic       w_sel_elig;
    logic       w_higher;
    logic [2:0] w_take;

    logic       r_int_req;
    logic       r_clr;
    logic       r_force;
    logic       w_int_req_nxt;
    logic       w_clr_nxt;
    logic       w_force_nxt;

    // Two-flop synchronizer followed by a third flop for rising-edge detection
    always_ff @(posedge clk or posedge in_RST) begin
        if (in_RST) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
            r_sync3 <= 3'b000;
        end else begin
            r_sync1 <= irq_btn;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_edge = r_sync2 & ~r_sync3;

    // Only levels strictly above the deepest nesting level may preempt
    always_comb begin
        w_above = 3'b111;
        if (r_in_service[2]) begin
            w_above = 3'b000;
        end else if (r_in_service[1]) begin
            w_above = 3'b100;
        end else if (r_in_service[0]) begin
            w_above = 3'b110;
        end
    end

    assign w_elig = r_pending & im & {3{ie}} & w_above;
    assign w_any  = |w_elig;

    always_comb begin
        w_win = 2'd0;
        if (w_elig[2]) begin
            w_win = 2'd2;
        end else if (w_elig[1]) begin
            w_win = 2'd1;
        end
    end

    assign w_sel_oh   = 3'b001 << r_sel;
    assign w_sel_elig = |(w_elig & w_sel_oh);
    assign w_higher   = w_any && (w_win > r_sel);
    assign w_take     = (r_state == c_jump) ? w_sel_oh : 3'b000;

    // State register
    always_ff @(posedge clk or posedge in_RST) begin
        if (in_RST) begin
            r_state   <= c_idle;
            r_sel     <= 2'd0;
            r_cnt     <= 3'd0;
            r_int_req <= 1'b0;
            r_clr     <= 1'b0;
            r_force   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_cnt     <= w_cnt_nxt;
            r_int_req <= w_int_req_nxt;
            r_clr     <= w_clr_nxt;
            r_force   <= w_force_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_idle: begin
                if (w_any) begin
                    w_sel_nxt   = w_win;
                    w_state_nxt = c_req;
                end
            end
            c_req: begin
                if (w_higher) begin
                    w_sel_nxt = w_win;
                end
                // A request whose level lost eligibility is withdrawn, pending kept
                if (!w_higher && !w_sel_elig) begin
                    w_state_nxt = c_idle;
                end else if (pipe_ack) begin
                    w_state_nxt = c_flush;
                    w_cnt_nxt   = 3'd0;
                end
            end
            c_flush: begin
                if (r_cnt == c_flush_last) begin
                    w_state_nxt = c_jump;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            c_jump: begin
                w_state_nxt = c_idle;
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    // Output logic, registered against the upcoming state
    always_comb begin
        w_int_req_nxt = (w_state_nxt == c_req);
        w_clr_nxt     = (w_state_nxt == c_flush);
        w_force_nxt   = (w_state_nxt == c_jump);
    end

    // eret pops the top of the nesting stack before any push from the jump
    always_comb begin
        w_isv_pop = r_in_service;
        if (eret) begin
            if (r_in_service[2]) begin
                w_isv_pop[2] = 1'b0;
            end else if (r_in_service[1]) begin
                w_isv_pop[1] = 1'b0;
            end else if (r_in_service[0]) begin
                w_isv_pop[0] = 1'b0;
            end
        end
    end

    assign w_isv_nxt     = w_isv_pop | w_take;
    assign w_pending_nxt = (r_pending & ~w_take) | w_edge;

    always_ff @(posedge clk or posedge in_RST) begin
        if (in_RST) begin
            r_pending    <= 3'b000;
            r_in_service <= 3'b000;
        end else begin
            r_pending    <= w_pending_nxt;
            r_in_service <= w_isv_nxt;
        end
    end

    always_comb begin
        faddr = 32'h0000_0000;
        if (r_state == c_jump) begin
            case (r_sel)
                2'd0:    faddr = VEC0;
                2'd1:    faddr = VEC1;
                default: faddr = VEC2;
            endcase
        end
    end

    assign int_req    = r_int_req;
    assign fd_clr     = r_clr;
    assign de_clr     = r_clr;
    assign ee_clr     = r_clr;
    assign pc_force   = r_force;
    assign save_epc   = r_force;
    assign pending    = r_pending;
    assign in_service = r_in_service;
    assign leds       = r_in_service;

endmodule
`default_nettype wire

// File: tb/tb_irq_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_sched
//  Purpose  : Directed and random stimulus for irq_sched against a
//             queue-based behavioural model of the interrupt scheduler.
//  Revision : 1.0
// ============================================================================
module tb_irq_sched;

    localparam int FLUSH_CYC = 2;
    localparam int P_IDLE = 0, P_REQ = 1, P_FLUSH = 2, P_JUMP = 3;

    logic        clk = 1'b0;
    logic        in_RST;
    logic [2:0]  irq_btn;
    logic        ie;
    logic [2:0]  im;
    logic        pipe_ack;
    logic        eret;
    logic        int_req, fd_clr, de_clr, ee_clr, pc_force, save_epc;
    logic [31:0] faddr;
    logic [2:0]  pending, in_service, leds;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model: button history, pending bits, nesting stack, phase
    logic [2:0] hq[$];
    bit   [2:0] m_pend;
    int         m_stack[$];
    int         m_phase, m_sel, m_left;

    irq_sched #(.FLUSH_CYC(FLUSH_CYC)) dut (
        .clk(clk), .in_RST(in_RST), .irq_btn(irq_btn), .ie(ie), .im(im),
        .pipe_ack(pipe_ack), .eret(eret), .int_req(int_req),
        .fd_clr(fd_clr), .de_clr(de_clr), .ee_clr(ee_clr),
        .pc_force(pc_force), .faddr(faddr), .save_epc(save_epc),
        .pending(pending), .in_service(in_service), .leds(leds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hq = '{3'b000, 3'b000, 3'b000};
        m_pend = 3'b000;
        m_stack.delete();
        m_phase = P_IDLE;
        m_sel = 0;
        m_left = 0;
    endtask

    function automatic bit can_take(int n, int top);
        return m_pend[n] && im[n] && ie && (n > top);
    endfunction

    task automatic model_step();
        bit [2:0] el;
        int top, win;
        logic [2:0] edges;
        top = (m_stack.size() == 0) ? -1 : m_stack[$];
        win = -1;
        for (int n = 0; n < 3; n++) begin
            el[n] = can_take(n, top);
            if (el[n]) win = n;
        end
        edges = hq[1] & ~hq[0];
        hq.push_back(irq_btn);
        void'(hq.pop_front());
        if (m_phase == P_JUMP) m_pend[m_sel] = 1'b0;
        m_pend = m_pend | edges;
        if (eret && m_stack.size() > 0) void'(m_stack.pop_back());
        if (m_phase == P_JUMP) m_stack.push_back(m_sel);
        case (m_phase)
            P_IDLE: if (win >= 0) begin m_sel = win; m_phase = P_REQ; end
            P_REQ: begin
                if (win > m_sel) m_sel = win;
                else if (!el[m_sel]) m_phase = P_IDLE;
                if (m_phase == P_REQ && pipe_ack) begin
                    m_phase = P_FLUSH;
                    m_left = FLUSH_CYC;
                end
            end
            P_FLUSH: begin
                m_left--;
                if (m_left == 0) m_phase = P_JUMP;
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic check_all();
        logic [2:0] isv;
        isv = 3'b000;
        foreach (m_stack[i]) isv[m_stack[i]] = 1'b1;
        chk("int_req", 32'(int_req), 32'(m_phase == P_REQ));
        chk("clears", 32'({fd_clr, de_clr, ee_clr}), (m_phase == P_FLUSH) ? 32'd7 : 32'd0);
        chk("force", 32'(pc_force), 32'(m_phase == P_JUMP));
        chk("save_epc", 32'(save_epc), 32'(m_phase == P_JUMP));
        chk("faddr", faddr, (m_phase == P_JUMP) ? 32'(32'h400 + 32'h100 * m_sel) : 32'd0);
        chk("pending", 32'(pending), 32'(m_pend));
        chk("in_service", 32'(in_service), 32'(isv));
        chk("leds", 32'(leds), 32'(isv));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic wait_force(input string tag);
        for (int k = 0; k < 30 && pc_force !== 1'b1; k++) cyc();
        chk(tag, 32'(pc_force), 32'd1);
    endtask

    task automatic wait_clr(input string tag);
        for (int k = 0; k < 30 && fd_clr !== 1'b1; k++) cyc();
        chk(tag, 32'(fd_clr), 32'd1);
    endtask

    task automatic eret_pulse();
        eret = 1'b1;
        cyc();
        eret = 1'b0;
    endtask

    initial begin
        in_RST = 1'b1; irq_btn = 3'b000; ie = 1'b0; im = 3'b000;
        pipe_ack = 1'b0; eret = 1'b0;
        model_reset();
        #12;
        chk("rst_outputs", 32'({int_req, fd_clr, de_clr, ee_clr, pc_force, save_epc}), 32'd0);
        chk("rst_faddr", faddr, 32'd0);
        chk("rst_state", 32'({pending, in_service, leds}), 32'd0);
        #10 in_RST = 1'b0;

        // Single interrupt with the documented latency
        ie = 1'b1; im = 3'b111; pipe_ack = 1'b1;
        irq_btn = 3'b001;
        cyc(); cyc(); cyc();
        chk("t1_pending_c3", 32'(pending), 32'd1);
        cyc();
        chk("t1_int_req_c4", 32'(int_req), 32'd1);
        irq_btn = 3'b000;
        cyc(); chk("t1_clr1", 32'(fd_clr & de_clr & ee_clr), 32'd1);
        cyc(); chk("t1_clr2", 32'(fd_clr & de_clr & ee_clr), 32'd1);
        cyc(); chk("t1_faddr", faddr, 32'h400);
        cyc(); chk("t1_isv", 32'(in_service), 32'd1);

        // Priority: levels 0 and 2 together
        eret_pulse();
        irq_btn = 3'b101;
        wait_force("t2_wait_force2");
        chk("t2_faddr2", faddr, 32'h600);
        irq_btn = 3'b000;
        cyc();
        eret_pulse();
        wait_force("t2_wait_force0");
        chk("t2_faddr0", faddr, 32'h400);
        cyc();
        eret_pulse();

        // Nesting
        irq_btn = 3'b001; wait_force("t3_take0"); irq_btn = 3'b000; cyc();
        irq_btn = 3'b010; wait_force("t3_take1");
        chk("t3_faddr1", faddr, 32'h500);
        irq_btn = 3'b000; cyc();
        chk("t3_isv011", 32'(in_service), 32'd3);
        irq_btn = 3'b001;
        for (int k = 0; k < 8; k++) cyc();
        chk("t3_no_req", 32'(int_req), 32'd0);
        chk("t3_pend0", 32'(pending), 32'd1);
        irq_btn = 3'b000;
        eret_pulse(); chk("t3_eret1", 32'(in_service), 32'd1);
        eret_pulse(); chk("t3_eret2", 32'(in_service), 32'd0);
        wait_force("t3_take0_again");
        chk("t3_faddr0", faddr, 32'h400);
        cyc(); eret_pulse();

        // Handshake stall and eligibility withdrawal
        pipe_ack = 1'b0;
        irq_btn = 3'b010;
        for (int k = 0; k < 4; k++) cyc();
        irq_btn = 3'b000;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("t4_hold_req", 32'(int_req), 32'd1);
            chk("t4_no_clr", 32'(fd_clr), 32'd0);
        end
        ie = 1'b0; cyc();
        chk("t4_req_drop", 32'(int_req), 32'd0);
        chk("t4_pend_kept", 32'(pending), 32'd2);
        ie = 1'b1; pipe_ack = 1'b1;
        wait_force("t4_take");
        chk("t4_faddr", faddr, 32'h500);
        cyc(); eret_pulse();

        // Edge cases: idle eret, same-cycle eret/jump, re-edge during jump
        eret_pulse(); chk("t5_idle_eret", 32'(in_service), 32'd0);
        irq_btn = 3'b010; wait_force("t5_take1"); irq_btn = 3'b000; cyc();
        chk("t5_isv010", 32'(in_service), 32'd2);
        irq_btn = 3'b100; cyc(); cyc(); irq_btn = 3'b000;
        wait_clr("t5_wait_clr");
        irq_btn = 3'b100;
        cyc(); cyc();
        chk("t5_force", 32'(pc_force), 32'd1);
        chk("t5_faddr", faddr, 32'h600);
        eret_pulse();
        chk("t5_isv100", 32'(in_service), 32'd4);
        chk("t5_pend_set_wins", 32'(pending), 32'd4);
        irq_btn = 3'b000;
        eret_pulse();
        wait_force("t5_retake2");
        cyc(); eret_pulse();

        // Asynchronous reset in the middle of the flush
        irq_btn = 3'b001; cyc(); cyc(); irq_btn = 3'b000;
        wait_clr("t6_wait_clr");
        #3 in_RST = 1'b1;
        #1;
        chk("t6_rst_ctrl", 32'({int_req, fd_clr, de_clr, ee_clr, pc_force, save_epc}), 32'd0);
        chk("t6_rst_faddr", faddr, 32'd0);
        chk("t6_rst_state", 32'({pending, in_service, leds}), 32'd0);
        #2 in_RST = 1'b0;
        model_reset();
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("t6_no_force", 32'(pc_force), 32'd0);
        end

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(15) == 0) irq_btn[b] = ~irq_btn[b];
            ie = ($urandom_range(15) != 0);
            for (int b = 0; b < 3; b++) im[b] = ($urandom_range(7) != 0);
            pipe_ack = ($urandom_range(3) != 0);
            eret = ($urandom_range(11) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
